// File: rtl/alu_op_sequencer_if.sv
// Bundle for the request, ALU-drive and result ports of alu_op_sequencer.
// master is the sequencer side; slave is the command source / ALU / consumer side.
interface alu_op_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_opcode;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_opcode;
    logic       res_illegal;
    logic       busy;

    modport master (
        input  in_valid, in_a, in_b, in_opcode, alu_out, res_ready,
        output in_ready, alu_a, alu_b, alu_opcode,
        output res_valid, res_data, res_opcode, res_illegal, busy
    );

    modport slave (
        output in_valid, in_a, in_b, in_opcode, alu_out, res_ready,
        input  in_ready, alu_a, alu_b, alu_opcode,
        input  res_valid, res_data, res_opcode, res_illegal, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Queues ALU requests, drives them onto a combinational ALU one at a time,
// waits a fixed settle time and returns each result on a valid/ready port.
module alu_op_sequencer #(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_sequencer_if.master  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

    logic [10:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop, empty;
    logic [10:0]   head;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [3:0]    opa_q, opb_q;
    logic [2:0]    opc_q;
    logic          opc_illegal;
    logic          capture;
    logic          res_valid_q, res_valid_d;
    logic [7:0]    res_data_q;
    logic [2:0]    res_opcode_q;
    logic          res_illegal_q;

    // Ready is forced low during reset so nothing is accepted in that cycle.
    assign bus.in_ready = !rst && (count_q != FULL_CNT);
    assign push         = bus.in_valid && bus.in_ready;
    assign empty        = (count_q == '0);
    assign head         = mem_q[rd_ptr_q];
    assign opc_illegal  = opc_q[2] & opc_q[1];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_opcode, bus.in_a, bus.in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        pop         = 1'b0;
        capture     = 1'b0;
        res_valid_d = res_valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    settle_d = SETTLE_INIT;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - SW'(1);
                end else begin
                    capture     = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    // Refill straight into ISSUE so a full queue streams without a bubble.
                    if (!empty) begin
                        pop      = 1'b1;
                        settle_d = SETTLE_INIT;
                        state_d  = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            settle_q      <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            opc_q         <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_opcode_q  <= '0;
            res_illegal_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            res_valid_q <= res_valid_d;
            if (pop) begin
                {opc_q, opa_q, opb_q} <= head;
            end
            if (capture) begin
                res_data_q    <= opc_illegal ? 8'h00 : bus.alu_out;
                res_opcode_q  <= opc_q;
                res_illegal_q <= opc_illegal;
            end
        end
    end

    assign bus.alu_a       = opa_q;
    assign bus.alu_b       = opb_q;
    assign bus.alu_opcode  = opc_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_opcode  = res_opcode_q;
    assign bus.res_illegal = res_illegal_q;
    assign bus.busy        = (state_q != S_IDLE) || !empty;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed requests push expected results,
// a negedge monitor pops and compares every accepted result.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_op_sequencer_if bus();

    alu_op_sequencer #(.DEPTH(4), .SETTLE_CYCLES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference combinational ALU; illegal opcodes return junk the DUT must mask.
    always_comb begin
        case (bus.alu_opcode)
            3'd0:    bus.alu_out = {4'h0, bus.alu_a | bus.alu_b};
            3'd1:    bus.alu_out = {4'h0, bus.alu_a ^ bus.alu_b};
            3'd2:    bus.alu_out = {4'h0, bus.alu_a & bus.alu_b};
            3'd3:    bus.alu_out = {4'h0, bus.alu_a} + {4'h0, bus.alu_b};
            3'd4:    bus.alu_out = {4'h0, bus.alu_a} - {4'h0, bus.alu_b};
            3'd5:    bus.alu_out = {4'h0, bus.alu_a} * {4'h0, bus.alu_b};
            default: bus.alu_out = 8'hA5;
        endcase
    end

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] opc;
        logic       ill;
    } exp_t;

    exp_t exp_q[$];
    int   xfer_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%0h required=none", bus.res_data);
            end else begin
                e = exp_q.pop_front();
                check("result{data,opc,ill}", {20'h0, bus.res_data, bus.res_opcode, bus.res_illegal},
                      {20'h0, e.data, e.opc, e.ill});
                xfer_cyc.push_back(cyc);
            end
        end
    end

    // Call just after a posedge; returns just after the accepting posedge with in_valid still high.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic [7:0] d, output int acc);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_opcode = op;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(exp_t'{data: d, opc: op, ill: (op >= 3'd6)});
                acc = cyc + 1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_drained"}, exp_q.size(), 0);
    endtask

    logic [3:0] va[6] = '{4'd1, 4'd3, 4'd9, 4'd2, 4'd10, 4'd6};
    logic [3:0] vb[6] = '{4'd2, 4'd4, 4'd4, 4'd7, 4'd5,  4'd6};
    logic [2:0] vo[6] = '{3'd3, 3'd5, 3'd4, 3'd4, 3'd1,  3'd0};
    logic [7:0] vd[6] = '{8'd3, 8'd12, 8'd5, 8'hFB, 8'd15, 8'd6};

    initial begin
        int acc, lat, base, accepts, idx;
        bit seen;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_opcode = '0;
        bus.res_ready = 1'b0;

        // Reset held for two edges
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_res", {bus.res_valid, bus.res_data, bus.res_opcode, bus.res_illegal}, 0);
        check("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_opcode}, 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_busy", bus.busy, 0);

        // Single ADD with latency
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        send(4'd12, 4'd15, 3'd3, 8'd27, acc);
        bus.in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                lat = cyc - acc;
                break;
            end
        end
        check("latency", lat, 2);
        @(negedge clk);
        check("single_pulse_valid", bus.res_valid, 0);
        drain("single");

        // Back-to-back stream
        @(posedge clk); #1;
        base = xfer_cyc.size();
        send(4'd15, 4'd13, 3'd0, 8'd15, acc);
        send(4'd11, 4'd3,  3'd1, 8'd8,  acc);
        send(4'd15, 4'd11, 3'd2, 8'd11, acc);
        send(4'd14, 4'd7,  3'd5, 8'd98, acc);
        bus.in_valid = 1'b0;
        drain("stream");
        for (int k = 0; k < 3; k++) begin
            if (xfer_cyc.size() > base + k + 1)
                check("stream_spacing", xfer_cyc[base+k+1] - xfer_cyc[base+k], 2);
            else
                check("stream_count", xfer_cyc.size() - base, 4);
        end

        // Backpressure fills the queue
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        accepts = 0;
        idx = 0;
        bus.in_valid  = 1'b1;
        bus.in_a      = va[0];
        bus.in_b      = vb[0];
        bus.in_opcode = vo[0];
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.in_ready && idx < 6) begin
                exp_q.push_back(exp_t'{data: vd[idx], opc: vo[idx], ill: 1'b0});
                accepts++;
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 6) begin
                bus.in_a      = va[idx];
                bus.in_b      = vb[idx];
                bus.in_opcode = vo[idx];
            end
        end
        @(negedge clk);
        check("bp_accepts", accepts, 5);
        check("bp_in_ready_full", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_held_result", {bus.res_valid, bus.res_data}, {1'b1, 8'd3});
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        drain("backpressure");

        // Illegal opcode
        @(posedge clk); #1;
        send(4'd5, 4'd8, 3'd6, 8'd0, acc);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("illegal_alu_drive", {bus.alu_a, bus.alu_b, bus.alu_opcode}, {4'd5, 4'd8, 3'd6});
        drain("illegal");
        repeat (3) @(negedge clk);
        check("alu_hold_in_idle", {bus.alu_a, bus.alu_b, bus.alu_opcode}, {4'd5, 4'd8, 3'd6});

        // Reset in ISSUE with three queued
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        send(4'd1, 4'd1, 3'd3, 8'd2, acc);
        send(4'd2, 4'd2, 3'd3, 8'd4, acc);
        send(4'd3, 4'd3, 3'd3, 8'd6, acc);
        send(4'd4, 4'd4, 3'd3, 8'd8, acc);
        bus.in_a      = 4'd5;
        bus.in_b      = 4'd5;
        bus.in_opcode = 3'd3;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        check("issue_before_reset", {bus.busy, bus.res_valid, bus.alu_a}, {1'b1, 1'b0, 4'd2});
        rst = 1'b1;
        bus.in_valid = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.res_valid) seen = 1'b1;
        end
        check("no_result_after_reset", seen, 0);
        check("busy_after_reset", bus.busy, 0);
        check("in_ready_after_reset", bus.in_ready, 1);
        @(posedge clk); #1;
        send(4'd7, 4'd8, 3'd3, 8'd15, acc);
        bus.in_valid = 1'b0;
        drain("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
